jk_bank_sequencer: RTL and testbench

- Command-driven controller for an external bank of WIDTH jkflipflop cells sharing one clock.
- Each command is turned into per-bit 2-bit JK codes: 00 hold, 01 clear, 10 set, 11 toggle.
- Codes are driven onto the bank; the bank's q outputs are read back.
- Supports single-shot set/clear/toggle/load and multi-step count-up, count-down and shift sequences, with a valid/ready command handshake and a done pulse.

---
 rtl/jk_bank_sequencer_if.sv | 27 ++
 rtl/jk_bank_sequencer.sv | 144 ++++++++++++++
 tb/tb_jk_bank_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/jk_bank_sequencer_if.sv
// Command handshake and JK-bank bus shared by the sequencer and its driver.
// The master side issues commands and returns bank q; the slave side is the sequencer.
interface jk_bank_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [2:0]           cmd_op;
    logic [WIDTH-1:0]     cmd_data;
    logic [3:0]           cmd_count;
    logic                 abort;
    logic [WIDTH-1:0]     q_in;
    logic [2*WIDTH-1:0]   jk_out;
    logic                 busy;
    logic                 done;
    logic                 wrap;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_count, abort, q_in,
        input  cmd_ready, jk_out, busy, done, wrap
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_count, abort, q_in,
        output cmd_ready, jk_out, busy, done, wrap
    );
endinterface

// File: rtl/jk_bank_sequencer.sv
// Turns set/clear/toggle/load/count/shift commands into per-cell JK codes for an
// external bank of JK flip-flops, alternating DRIVE and SETTLE cycles per step.
module jk_bank_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    jk_bank_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StDrive, StSettle} state_e;

    localparam logic [2:0] OpNop    = 3'b000;
    localparam logic [2:0] OpClear  = 3'b001;
    localparam logic [2:0] OpSet    = 3'b010;
    localparam logic [2:0] OpToggle = 3'b011;
    localparam logic [2:0] OpLoad   = 3'b100;
    localparam logic [2:0] OpCntUp  = 3'b101;
    localparam logic [2:0] OpCntDn  = 3'b110;
    localparam logic [2:0] OpShl    = 3'b111;

    state_e               r_state, w_state_d;
    logic [2:0]           r_op, w_op_d;
    logic [WIDTH-1:0]     r_data, w_data_d;
    logic [3:0]           r_steps, w_steps_d;
    logic [2*WIDTH-1:0]   r_jk, w_jk_d;
    logic                 r_done, w_done_d;
    logic                 r_wrap, w_wrap_d;

    logic [2:0]           w_cur_op;
    logic [WIDTH-1:0]     w_cur_data;
    logic [2*WIDTH-1:0]   w_pat;
    logic                 w_wrap_hit;

    // Per-cell {J,K}; counters use the ripple-carry rule on the current q.
    function automatic logic [2*WIDTH-1:0] calc_pattern(input logic [2:0]       op,
                                                        input logic [WIDTH-1:0] data,
                                                        input logic [WIDTH-1:0] q);
        logic [2*WIDTH-1:0] pat;
        logic [WIDTH-1:0]   shifted;
        logic               all_ones;
        logic               all_zeros;
        pat       = '0;
        shifted   = {q[WIDTH-2:0], data[0]};
        all_ones  = 1'b1;
        all_zeros = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            case (op)
                OpClear:  pat[2*i +: 2] = 2'b01;
                OpSet:    pat[2*i +: 2] = 2'b10;
                OpToggle: pat[2*i +: 2] = data[i] ? 2'b11 : 2'b00;
                OpLoad:   pat[2*i +: 2] = data[i] ? 2'b10 : 2'b01;
                OpCntUp:  pat[2*i +: 2] = all_ones ? 2'b11 : 2'b00;
                OpCntDn:  pat[2*i +: 2] = all_zeros ? 2'b11 : 2'b00;
                OpShl:    pat[2*i +: 2] = shifted[i] ? 2'b10 : 2'b01;
                default:  pat[2*i +: 2] = 2'b00;
            endcase
            all_ones  = all_ones & q[i];
            all_zeros = all_zeros & ~q[i];
        end
        return pat;
    endfunction

    // In IDLE the pattern comes from the live command; later steps use the captured one.
    assign w_cur_op   = (r_state == StIdle) ? bus.cmd_op : r_op;
    assign w_cur_data = (r_state == StIdle) ? bus.cmd_data : r_data;
    assign w_pat      = calc_pattern(w_cur_op, w_cur_data, bus.q_in);
    assign w_wrap_hit = ((w_cur_op == OpCntUp) && (&bus.q_in)) ||
                        ((w_cur_op == OpCntDn) && !(|bus.q_in));

    always_comb begin
        w_state_d = r_state;
        w_op_d    = r_op;
        w_data_d  = r_data;
        w_steps_d = r_steps;
        w_jk_d    = '0;
        w_done_d  = 1'b0;
        w_wrap_d  = r_wrap;
        case (r_state)
            StIdle: begin
                if (bus.cmd_valid) begin
                    w_op_d    = bus.cmd_op;
                    w_data_d  = bus.cmd_data;
                    w_steps_d = (bus.cmd_op >= OpCntUp) ? bus.cmd_count : 4'd0;
                    if (bus.cmd_op == OpNop) begin
                        w_done_d = 1'b1;
                    end else begin
                        w_state_d = StDrive;
                        w_jk_d    = w_pat;
                        w_wrap_d  = w_wrap_hit;
                    end
                end
            end
            StDrive: begin
                w_state_d = bus.abort ? StIdle : StSettle;
            end
            StSettle: begin
                if (bus.abort) begin
                    w_state_d = StIdle;
                end else if (r_steps != 4'd0) begin
                    w_state_d = StDrive;
                    w_steps_d = r_steps - 4'd1;
                    w_jk_d    = w_pat;
                    if (w_wrap_hit) begin
                        w_wrap_d = 1'b1;
                    end
                end else begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_op    <= OpNop;
            r_data  <= '0;
            r_steps <= 4'd0;
            r_jk    <= '0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_op    <= w_op_d;
            r_data  <= w_data_d;
            r_steps <= w_steps_d;
            r_jk    <= w_jk_d;
            r_done  <= w_done_d;
            r_wrap  <= w_wrap_d;
        end
    end

    assign bus.cmd_ready = (r_state == StIdle);
    assign bus.busy      = (r_state != StIdle);
    assign bus.jk_out    = r_jk;
    assign bus.done      = r_done;
    assign bus.wrap      = r_wrap;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench: the sequencer drives a 4-cell behavioural JK bank whose q feeds back.
module tb_jk_bank_sequencer;

    localparam int unsigned W = 4;

    localparam logic [2:0] NOP    = 3'b000;
    localparam logic [2:0] CLEAR  = 3'b001;
    localparam logic [2:0] SET    = 3'b010;
    localparam logic [2:0] TOGGLE = 3'b011;
    localparam logic [2:0] LOAD   = 3'b100;
    localparam logic [2:0] CNT_UP = 3'b101;
    localparam logic [2:0] CNT_DN = 3'b110;
    localparam logic [2:0] SHL    = 3'b111;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] bank_q = '0;
    int           checks   = 0;
    int           failures = 0;

    jk_bank_sequencer_if #(.WIDTH(W)) u_if ();

    jk_bank_sequencer #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign u_if.q_in = bank_q;

    // Behavioural JK bank: 00 hold, 01 clear, 10 set, 11 toggle.
    always @(posedge clk) begin
        for (int i = 0; i < int'(W); i++) begin
            case (u_if.jk_out[2*i +: 2])
                2'b01:   bank_q[i] <= 1'b0;
                2'b10:   bank_q[i] <= 1'b1;
                2'b11:   bank_q[i] <= ~bank_q[i];
                default: bank_q[i] <= bank_q[i];
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a command for one edge; the DUT is expected to be in IDLE.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] d, input logic [3:0] c);
        u_if.cmd_op    = op;
        u_if.cmd_data  = d;
        u_if.cmd_count = c;
        u_if.cmd_valid = 1'b1;
        tick();
        u_if.cmd_valid = 1'b0;
    endtask

    // Issue and wait (bounded) for done; returns in the done cycle.
    task automatic run(input string tag, input logic [2:0] op, input logic [W-1:0] d);
        logic seen;
        seen = 1'b0;
        issue(op, d, 4'd0);
        for (int k = 0; k < 40 && !seen; k++) begin
            if (u_if.done) seen = 1'b1;
            else tick();
        end
        check(tag, seen, 1'b1);
    endtask

    initial begin
        rst_n          = 1'b0;
        u_if.cmd_valid = 1'b0;
        u_if.cmd_op    = NOP;
        u_if.cmd_data  = '0;
        u_if.cmd_count = 4'd0;
        u_if.abort     = 1'b0;
        tick();
        tick();
        check("rst_jk", u_if.jk_out, 8'h00);
        check("rst_ready", u_if.cmd_ready, 1'b1);
        check("rst_busy", u_if.busy, 1'b0);
        check("rst_done", u_if.done, 1'b0);
        check("rst_wrap", u_if.wrap, 1'b0);
        rst_n = 1'b1;
        tick();

        // Reset asserted in the middle of a CNT_UP drive cycle
        issue(CNT_UP, 4'b0000, 4'd3);
        check("t1_drive_jk", u_if.jk_out, 8'b0000_0011);
        check("t1_drive_busy", u_if.busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_async_jk", u_if.jk_out, 8'h00);
        check("t1_async_ready", u_if.cmd_ready, 1'b1);
        check("t1_async_busy", u_if.busy, 1'b0);
        check("t1_async_done", u_if.done, 1'b0);
        tick();
        check("t1_bank_held", bank_q, 4'b0000);
        rst_n = 1'b1;
        tick();
        check("t1_no_done", u_if.done, 1'b0);
        check("t1_bank_after", bank_q, 4'b0000);

        // LOAD 1010, then TOGGLE 0110 accepted in the done cycle
        issue(LOAD, 4'b1010, 4'd0);
        check("t2_load_jk", u_if.jk_out, 8'b1001_1001);
        check("t2_c1_done", u_if.done, 1'b0);
        tick();
        check("t2_settle_q", bank_q, 4'b1010);
        check("t2_settle_jk", u_if.jk_out, 8'h00);
        check("t2_c2_done", u_if.done, 1'b0);
        tick();
        check("t2_c3_done", u_if.done, 1'b1);
        check("t2_c3_ready", u_if.cmd_ready, 1'b1);
        issue(TOGGLE, 4'b0110, 4'd0);
        check("t2_tog_jk", u_if.jk_out, 8'b0011_1100);
        tick();
        tick();
        check("t2_tog_q", bank_q, 4'b1100);
        check("t2_tog_done", u_if.done, 1'b1);
        tick();
        check("t2_done_pulse", u_if.done, 1'b0);

        // CNT_UP x4 from 1101 wraps through 1111 -> 0000
        run("t3_preload", LOAD, 4'b1101);
        issue(CNT_UP, 4'b0000, 4'd3);
        check("t3_jk1", u_if.jk_out, 8'b0000_1111);
        tick();
        check("t3_q1", bank_q, 4'b1110);
        tick();
        tick();
        check("t3_q2", bank_q, 4'b1111);
        check("t3_nowrap", u_if.wrap, 1'b0);
        tick();
        check("t3_wrap_set", u_if.wrap, 1'b1);
        check("t3_jk3", u_if.jk_out, 8'b1111_1111);
        tick();
        check("t3_q3", bank_q, 4'b0000);
        tick();
        tick();
        check("t3_q4", bank_q, 4'b0001);
        check("t3_c8_done", u_if.done, 1'b0);
        tick();
        check("t3_c9_done", u_if.done, 1'b1);
        check("t3_wrap_keep", u_if.wrap, 1'b1);

        // CNT_DN from 0000 wraps; next CLEAR accept clears wrap
        run("t4_clear", CLEAR, 4'b0000);
        check("t4_wrap_clr0", u_if.wrap, 1'b0);
        check("t4_q0", bank_q, 4'b0000);
        issue(CNT_DN, 4'b0000, 4'd0);
        check("t4_dn_jk", u_if.jk_out, 8'hff);
        check("t4_dn_wrap", u_if.wrap, 1'b1);
        tick();
        check("t4_dn_q", bank_q, 4'b1111);
        tick();
        check("t4_dn_done", u_if.done, 1'b1);
        issue(CLEAR, 4'b0000, 4'd0);
        check("t4_wrap_clr", u_if.wrap, 1'b0);
        tick();
        tick();
        check("t4_clr_q", bank_q, 4'b0000);
        check("t4_clr_done", u_if.done, 1'b1);

        // SHL with serial-in 1, then an aborted SHL
        run("t5_preload", LOAD, 4'b0011);
        issue(SHL, 4'b0001, 4'd1);
        check("t5_shl_jk", u_if.jk_out, 8'b0110_1010);
        tick();
        check("t5_shl_q1", bank_q, 4'b0111);
        tick();
        tick();
        check("t5_shl_q2", bank_q, 4'b1111);
        tick();
        check("t5_shl_done", u_if.done, 1'b1);
        issue(SHL, 4'b0000, 4'd3);
        tick();
        check("t5_ab_q1", bank_q, 4'b1110);
        tick();
        tick();
        check("t5_ab_q2", bank_q, 4'b1100);
        u_if.abort = 1'b1;
        tick();
        u_if.abort = 1'b0;
        check("t5_ab_busy", u_if.busy, 1'b0);
        check("t5_ab_ready", u_if.cmd_ready, 1'b1);
        check("t5_ab_jk", u_if.jk_out, 8'h00);
        check("t5_ab_done", u_if.done, 1'b0);
        tick();
        check("t5_ab_done2", u_if.done, 1'b0);
        check("t5_ab_q", bank_q, 4'b1100);

        // NOP, then CLEAR, with SET held on cmd_valid until ready (abort high at accept)
        u_if.cmd_op    = NOP;
        u_if.cmd_valid = 1'b1;
        tick();
        check("t6_nop_done", u_if.done, 1'b1);
        check("t6_nop_busy", u_if.busy, 1'b0);
        check("t6_nop_jk", u_if.jk_out, 8'h00);
        u_if.cmd_op = CLEAR;
        tick();
        check("t6_clr_busy", u_if.busy, 1'b1);
        u_if.cmd_op = SET;
        tick();
        check("t6_hold_ready", u_if.cmd_ready, 1'b0);
        check("t6_hold_q", bank_q, 4'b0000);
        tick();
        check("t6_clr_done", u_if.done, 1'b1);
        check("t6_ready", u_if.cmd_ready, 1'b1);
        u_if.abort = 1'b1;
        tick();
        u_if.abort     = 1'b0;
        u_if.cmd_valid = 1'b0;
        check("t6_set_busy", u_if.busy, 1'b1);
        check("t6_set_jk", u_if.jk_out, 8'b1010_1010);
        tick();
        check("t6_set_q", bank_q, 4'b1111);
        tick();
        check("t6_set_done", u_if.done, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
